// File: rtl/ps2_key_event_fifo.sv
// PS/2 set-2 scan-code decoder feeding a show-ahead event FIFO.
// Events are {brk, ext, code}; irq/overflow are sticky until int_clear.
module ps2_key_event_fifo #(
  parameter int DEPTH          = 8,
  parameter int PREFIX_TIMEOUT = 50000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       in_valid,
  input  logic [7:0] in_data,
  input  logic       rd_en,
  input  logic       int_clear,
  output logic [9:0] rd_data,
  output logic       empty,
  output logic       full,
  output logic [4:0] count,
  output logic       overflow,
  output logic       irq
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int TW = $clog2(PREFIX_TIMEOUT + 1);
  localparam logic [TW-1:0] TO_LAST = TW'(PREFIX_TIMEOUT - 1);

  typedef enum logic [2:0] {IDLE, E0, F0, E0F0, SKIP} state_t;

  state_t         state_q, state_d;
  logic [2:0]     skip_q, skip_d;
  logic [TW-1:0]  to_q, to_d;
  logic [AW-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [4:0]     count_q, count_d;
  logic           ovf_q, ovf_d, irq_q, irq_d;
  logic [9:0]     mem_q [DEPTH];

  logic           push;
  logic [9:0]     push_data;
  logic           do_push, do_pop, drop;

  // Decoder: bytes are only examined on in_valid; idle prefixes time out.
  always_comb begin
    state_d   = state_q;
    skip_d    = skip_q;
    to_d      = to_q;
    push      = 1'b0;
    push_data = 10'h000;
    if (in_valid) begin
      to_d = '0;
      unique case (state_q)
        IDLE: begin
          unique case (in_data)
            8'hE0: state_d = E0;
            8'hF0: state_d = F0;
            8'hE1: begin
              state_d = SKIP;
              skip_d  = 3'd7;
            end
            8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFE, 8'hFF: ;
            default: begin
              push      = 1'b1;
              push_data = {2'b00, in_data};
            end
          endcase
        end
        E0: begin
          if (in_data == 8'hF0) state_d = E0F0;
          else if (in_data != 8'hE0) begin
            push      = 1'b1;
            push_data = {2'b01, in_data};
            state_d   = IDLE;
          end
        end
        F0: begin
          push      = 1'b1;
          push_data = {2'b10, in_data};
          state_d   = IDLE;
        end
        E0F0: begin
          push      = 1'b1;
          push_data = {2'b11, in_data};
          state_d   = IDLE;
        end
        SKIP: begin
          skip_d = skip_q - 3'd1;
          if (skip_q == 3'd1) begin
            push      = 1'b1;
            push_data = {2'b01, 8'hE1};
            state_d   = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end else if (state_q == IDLE) begin
      to_d = '0;
    end else if (to_q == TO_LAST) begin
      state_d = IDLE;
      skip_d  = 3'd0;
      to_d    = '0;
    end else begin
      to_d = to_q + 1'b1;
    end
  end

  assign empty = (count_q == 5'd0);
  assign full  = (count_q == 5'(DEPTH));

  // A pop while full frees the slot the simultaneous push lands in.
  always_comb begin
    do_pop   = rd_en && !empty;
    do_push  = push && (!full || do_pop);
    drop     = push && !do_push;
    wr_ptr_d = do_push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = do_pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d  = count_q + {4'b0, do_push} - {4'b0, do_pop};
    irq_d    = do_push ? 1'b1 : (int_clear ? 1'b0 : irq_q);
    ovf_d    = drop    ? 1'b1 : (int_clear ? 1'b0 : ovf_q);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      skip_q   <= 3'd0;
      to_q     <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= 5'd0;
      ovf_q    <= 1'b0;
      irq_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      skip_q   <= skip_d;
      to_q     <= to_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      irq_q    <= irq_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && do_push) mem_q[wr_ptr_q] <= push_data;
  end

  assign rd_data  = empty ? 10'h000 : mem_q[rd_ptr_q];
  assign count    = count_q;
  assign overflow = ovf_q;
  assign irq      = irq_q;
endmodule

// File: tb/tb_ps2_key_event_fifo.sv
// Directed bench for ps2_key_event_fifo: a vector table plus corner-case sequences.
module tb_ps2_key_event_fifo;
  localparam int DEPTH = 4;
  localparam int TO    = 20;

  logic       clk = 1'b0;
  logic       reset, in_valid, rd_en, int_clear;
  logic [7:0] in_data;
  logic [9:0] rd_data;
  logic       empty, full, overflow, irq;
  logic [4:0] count;

  int checks = 0;
  int errors = 0;

  ps2_key_event_fifo #(.DEPTH(DEPTH), .PREFIX_TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
    .rd_en(rd_en), .int_clear(int_clear), .rd_data(rd_data), .empty(empty),
    .full(full), .count(count), .overflow(overflow), .irq(irq)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst, iv;
    logic [7:0] d;
    logic       rd, clr;
    logic       e, f;
    logic [4:0] c;
    logic [9:0] q;
    logic       irq, ov;
  } vec_t;

  vec_t tbl [19];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Apply the currently driven inputs across one edge, then idle them.
  task automatic tick();
    @(posedge clk);
    #1;
    reset = 0; in_valid = 0; in_data = 8'h00; rd_en = 0; int_clear = 0;
  endtask

  task automatic send(input logic [7:0] b);
    in_valid = 1; in_data = b;
    tick();
  endtask

  task automatic pop_chk(input string name, input logic [9:0] exp);
    chk(name, {22'b0, rd_data}, {22'b0, exp});
    rd_en = 1;
    tick();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    reset = 1; in_valid = 0; in_data = 8'h00; rd_en = 0; int_clear = 0;
    //          rst iv  d      rd clr  e  f  c     q        irq ov
    tbl[0]  = '{1, 0, 8'h00, 0, 0,   1, 0, 5'd0, 10'h000, 0, 0};
    tbl[1]  = '{0, 1, 8'h1C, 0, 0,   0, 0, 5'd1, 10'h01C, 1, 0};
    tbl[2]  = '{0, 1, 8'hF0, 0, 0,   0, 0, 5'd1, 10'h01C, 1, 0};
    tbl[3]  = '{0, 1, 8'h1C, 0, 0,   0, 0, 5'd2, 10'h01C, 1, 0};
    tbl[4]  = '{0, 0, 8'h00, 1, 1,   0, 0, 5'd1, 10'h21C, 0, 0};
    tbl[5]  = '{0, 0, 8'h00, 1, 0,   1, 0, 5'd0, 10'h000, 0, 0};
    tbl[6]  = '{0, 0, 8'h00, 1, 0,   1, 0, 5'd0, 10'h000, 0, 0};
    tbl[7]  = '{0, 1, 8'hE0, 0, 0,   1, 0, 5'd0, 10'h000, 0, 0};
    tbl[8]  = '{0, 1, 8'h75, 0, 0,   0, 0, 5'd1, 10'h175, 1, 0};
    tbl[9]  = '{0, 1, 8'hE0, 0, 0,   0, 0, 5'd1, 10'h175, 1, 0};
    tbl[10] = '{0, 1, 8'hF0, 0, 0,   0, 0, 5'd1, 10'h175, 1, 0};
    tbl[11] = '{0, 1, 8'h75, 0, 0,   0, 0, 5'd2, 10'h175, 1, 0};
    tbl[12] = '{0, 1, 8'hFA, 0, 0,   0, 0, 5'd2, 10'h175, 1, 0};
    tbl[13] = '{0, 1, 8'hAA, 0, 0,   0, 0, 5'd2, 10'h175, 1, 0};
    tbl[14] = '{0, 0, 8'h00, 1, 0,   0, 0, 5'd1, 10'h375, 1, 0};
    tbl[15] = '{0, 1, 8'h1C, 1, 1,   0, 0, 5'd1, 10'h01C, 1, 0};
    tbl[16] = '{0, 0, 8'h00, 1, 0,   1, 0, 5'd0, 10'h000, 1, 0};
    tbl[17] = '{0, 1, 8'h1C, 1, 0,   0, 0, 5'd1, 10'h01C, 1, 0};
    tbl[18] = '{0, 0, 8'h00, 1, 1,   1, 0, 5'd0, 10'h000, 0, 0};

    for (int i = 0; i < 19; i++) begin
      reset = tbl[i].rst; in_valid = tbl[i].iv; in_data = tbl[i].d;
      rd_en = tbl[i].rd; int_clear = tbl[i].clr;
      tick();
      chk($sformatf("v%0d.empty", i), {31'b0, empty}, {31'b0, tbl[i].e});
      chk($sformatf("v%0d.full", i), {31'b0, full}, {31'b0, tbl[i].f});
      chk($sformatf("v%0d.count", i), {27'b0, count}, {27'b0, tbl[i].c});
      chk($sformatf("v%0d.rd_data", i), {22'b0, rd_data}, {22'b0, tbl[i].q});
      chk($sformatf("v%0d.irq", i), {31'b0, irq}, {31'b0, tbl[i].irq});
      chk($sformatf("v%0d.overflow", i), {31'b0, overflow}, {31'b0, tbl[i].ov});
    end

    // Pause sequence collapses to a single event, then FSM is idle again.
    begin
      logic [7:0] pause [8];
      pause = '{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77};
      foreach (pause[k]) send(pause[k]);
    end
    chk("pause.count", {27'b0, count}, 32'd1);
    pop_chk("pause.event", 10'h1E1);
    send(8'h1C);
    chk("pause.idle_after", {22'b0, rd_data}, 32'h01C);
    rd_en = 1; tick();

    // Prefix timeout boundary: one cycle short still breaks, full timeout makes.
    send(8'hF0); idle(TO - 1); send(8'h1C);
    pop_chk("to.short", 10'h21C);
    send(8'hF0); idle(TO); send(8'h1C);
    chk("to.count", {27'b0, count}, 32'd1);
    pop_chk("to.expired", 10'h01C);
    int_clear = 1; tick();

    // Overflow, push+pop while full, dropped push alongside int_clear.
    for (int k = 0; k <= DEPTH; k++) send(8'h11 + 8'(k));
    chk("ovf.full", {31'b0, full}, 32'd1);
    chk("ovf.count", {27'b0, count}, DEPTH);
    chk("ovf.flag", {31'b0, overflow}, 32'd1);
    int_clear = 1; tick();
    chk("ovf.cleared", {30'b0, overflow, irq}, 32'd0);
    in_valid = 1; in_data = 8'h16; rd_en = 1; tick();
    chk("pp.count", {27'b0, count}, DEPTH);
    chk("pp.ovf", {31'b0, overflow}, 32'd0);
    chk("pp.irq", {31'b0, irq}, 32'd1);
    in_valid = 1; in_data = 8'h17; int_clear = 1; tick();
    chk("drop_clr.ovf", {31'b0, overflow}, 32'd1);
    chk("drop_clr.irq", {31'b0, irq}, 32'd0);
    pop_chk("rb0", 10'h012);
    pop_chk("rb1", 10'h013);
    pop_chk("rb2", 10'h014);
    pop_chk("rb3", 10'h016);
    chk("rb.empty", {31'b0, empty}, 32'd1);

    // Reset mid-prefix with events queued.
    send(8'h21); send(8'h22); send(8'h23); send(8'hE0);
    reset = 1; in_valid = 1; in_data = 8'h24; rd_en = 1; tick();
    chk("rst.empty", {31'b0, empty}, 32'd1);
    chk("rst.count", {27'b0, count}, 32'd0);
    chk("rst.irq_ovf", {30'b0, irq, overflow}, 32'd0);
    chk("rst.rd_data", {22'b0, rd_data}, 32'd0);
    send(8'h75);
    chk("rst.after", {22'b0, rd_data}, 32'h075);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/ps2_key_event_fifo.md
PS2_KEY_EVENT_FIFO -- requirements
Module: ps2_key_event_fifo

Interface
REQ-001 SHALL have parameter DEPTH, default 8, event FIFO entries (power of two, 2..16).
REQ-002 SHALL have parameter PREFIX_TIMEOUT, default 50000, idle clk cycles after which a pending prefix is abandoned (2 ms at 25 MHz).
REQ-003 SHALL have port clk  input  1  system clock, 25 MHz; all logic on posedge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port in_valid  input  1  one-cycle pulse, in_data holds a received PS/2 byte.
REQ-006 SHALL have port in_data  input  8  received scan-code byte (set 2).
REQ-007 SHALL have port rd_en  input  1  pop oldest event.
REQ-008 SHALL have port int_clear  input  1  clears irq and overflow.
REQ-009 SHALL have port rd_data  output  10  oldest event {brk, ext, code[7:0]}, show-ahead.
REQ-010 SHALL have port empty  output  1  FIFO holds no events.
REQ-011 SHALL have port full  output  1  FIFO holds DEPTH events.
REQ-012 SHALL have port count  output  5  events held, 0..DEPTH.
REQ-013 SHALL have port overflow  output  1  sticky, an event was dropped.
REQ-014 SHALL have port irq  output  1  sticky, an event was stored.

Function
REQ-015 SHALL run a decoder FSM with states IDLE, E0, F0, E0F0, SKIP; in_data is examined only in cycles where in_valid=1.
REQ-016 IDLE: 0xE0->E0; 0xF0->F0; 0xE1->SKIP with skip counter=7; 0x00, 0xAA, 0xEE, 0xFA, 0xFE, 0xFF discarded, stay IDLE; any other b SHALL push {0,0,b}.
REQ-017 E0: 0xF0->E0F0; 0xE0 stays E0; any other b SHALL push {0,1,b} and return to IDLE.
REQ-018 F0: any b SHALL push {1,0,b} and return to IDLE.
REQ-019 E0F0: any b SHALL push {1,1,b} and return to IDLE.
REQ-020 SKIP: each byte decrements the skip counter; the byte that takes it to 0 SHALL push {0,1,0xE1} (Pause) and return to IDLE.
REQ-021 In E0, F0, E0F0 or SKIP, PREFIX_TIMEOUT consecutive cycles without in_valid SHALL return the FSM to IDLE with no push; the timeout counter SHALL clear on every in_valid and in IDLE.
REQ-022 Push latency: an event from an in_valid in cycle N SHALL be stored at the clk edge ending cycle N, visible on rd_data, empty and count in cycle N+1.
REQ-023 rd_data SHALL equal the oldest entry while empty=0; while empty=1 it SHALL be 10'h000.
REQ-024 rd_en with empty=0 SHALL remove the oldest entry at that edge; rd_en with empty=1 SHALL be ignored.
REQ-025 Push with full=0 SHALL store; push with full=1 and no pop SHALL drop the event and set overflow.
REQ-026 Push and pop in the same cycle while full=1 SHALL both succeed, count unchanged, overflow unaffected.
REQ-027 Push and pop in the same cycle while empty=1 SHALL store the push and ignore the pop.
REQ-028 Read/write pointers SHALL wrap modulo DEPTH; full and empty SHALL derive from count, never from pointer equality alone.
REQ-029 irq SHALL set on every successful push; int_clear SHALL clear irq and overflow; a successful push in the same cycle as int_clear SHALL leave irq=1.
REQ-030 A dropped push in the same cycle as int_clear SHALL leave overflow=1.

Reset
REQ-031 reset=1 at a clk edge SHALL force FSM=IDLE, skip and timeout counters=0, pointers=0, count=0, empty=1, full=0, rd_data=0, overflow=0, irq=0.
REQ-032 in_valid, rd_en and int_clear SHALL be ignored in any cycle where reset=1; a prefix in progress SHALL be lost.
REQ-033 FIFO contents need not be cleared by reset, but SHALL never be visible while empty=1.

Verification
REQ-034 Bytes 0x1C; 0xF0,0x1C -> events 0x01C, 0x21C in order; irq=1 after the first push; count=2.
REQ-035 Bytes 0xE0,0x75; 0xE0,0xF0,0x75 -> events 0x175, 0x375; bytes 0xFA, 0xAA -> no events.
REQ-036 Bytes E1 14 77 E1 F0 14 F0 77 -> exactly one event 0x1E1, FSM back in IDLE.
REQ-037 0xF0 then PREFIX_TIMEOUT idle cycles, then 0x1C -> single event 0x01C (make, not break).
REQ-038 DEPTH+1 make codes with no reads -> full=1, count=DEPTH, overflow=1, first DEPTH events read back in order; push+pop while full -> count stays DEPTH, overflow unchanged.
REQ-039 reset asserted after 0xE0 with 3 events queued -> empty=1, count=0, irq=0; then 0x75 -> event 0x075.
